// File: rtl/matrix_scan_driver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matrix_scan_driver_pkg : scan FSM encoding and shared helpers      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package matrix_scan_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_scan_driver_scan_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matrix_scan_driver_scan_timer : loadable down-counter, terminal cnt |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module matrix_scan_driver_scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // tc marks the final cycle of the loaded interval; zero also counts so a
  // stray empty count can never stall the scan.
  assign tc = (count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | matrix_scan_driver : double-buffered self-timed LED row scanner    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module matrix_scan_driver
  import matrix_scan_driver_pkg::*;
#(
  parameter int COLS        = 5,
  parameter int ROWS        = 7,
  parameter int DWELL_CYC   = 1000,
  parameter int BLANK_CYC   = 50,
  parameter int ROW_ACT_LOW = 0,
  parameter int COL_ACT_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic [ROWS-1:0]      row_out,
  output logic [COLS-1:0]      col_out,
  output logic                 frame_done
);

  localparam int CNT_W = $clog2(max2(DWELL_CYC, BLANK_CYC) + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] BLANK_LEN = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] DWELL_LEN = CNT_W'(DWELL_CYC);
  localparam logic             HAS_BLANK = (BLANK_CYC > 0);

  // With no blanking configured every row starts directly in SHOW.
  localparam scan_state_t      ROW_START     = HAS_BLANK ? ST_BLANK : ST_SHOW;
  localparam logic [CNT_W-1:0] ROW_START_LEN = HAS_BLANK ? BLANK_LEN : DWELL_LEN;

  localparam logic [ROWS-1:0] ROW_OFF = (ROW_ACT_LOW != 0) ? '1 : '0;
  localparam logic [COLS-1:0] COL_OFF = (COL_ACT_LOW != 0) ? '1 : '0;

  scan_state_t          state, nxt_state;
  logic [ROW_W-1:0]     row, nxt_row;
  logic [ROWS*COLS-1:0] shadow, nxt_shadow;
  logic [ROWS*COLS-1:0] active, nxt_active;
  logic                 pending, nxt_pending;
  logic                 nxt_done;
  logic                 swap;

  logic                 tmr_clear;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_tc;

  logic [ROWS-1:0]      row_hot;
  logic [COLS-1:0]      col_sel;

  matrix_scan_driver_scan_timer #(
    .WIDTH (CNT_W)
  ) u_scan_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_comb begin
    nxt_state   = state;
    nxt_row     = row;
    nxt_shadow  = shadow;
    nxt_active  = active;
    nxt_pending = pending;
    nxt_done    = 1'b0;
    swap        = 1'b0;
    tmr_clear   = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    // A swap always needs pending=1, which blocks a load on the same edge.
    if (load_valid && !pending) begin
      nxt_shadow  = frame_in;
      nxt_pending = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (!en) begin
          swap = pending;
        end else begin
          nxt_row   = '0;
          nxt_state = ROW_START;
          tmr_load  = 1'b1;
          tmr_val   = ROW_START_LEN;
        end
      end

      ST_BLANK: begin
        if (!en) begin
          nxt_state = ST_IDLE;
          nxt_row   = '0;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          nxt_state = ST_SHOW;
          tmr_load  = 1'b1;
          tmr_val   = DWELL_LEN;
        end
      end

      ST_SHOW: begin
        if (!en) begin
          nxt_state = ST_IDLE;
          nxt_row   = '0;
          tmr_clear = 1'b1;
        end else if (tmr_tc) begin
          nxt_state = ROW_START;
          tmr_load  = 1'b1;
          tmr_val   = ROW_START_LEN;
          if (row == LAST_ROW) begin
            nxt_row  = '0;
            nxt_done = 1'b1;
            swap     = pending;
          end else begin
            nxt_row = row + ROW_W'(1);
          end
        end
      end

      default: begin
        nxt_state = ST_IDLE;
        nxt_row   = '0;
        tmr_clear = 1'b1;
      end
    endcase

    if (swap) begin
      nxt_active  = shadow;
      nxt_pending = 1'b0;
    end
  end

  // Outputs are decoded from the next row/image so they move with the state.
  always_comb begin
    row_hot = '0;
    col_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (nxt_row == ROW_W'(r)) begin
        row_hot[r] = 1'b1;
        col_sel    = nxt_active[r*COLS +: COLS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      row_out    <= ROW_OFF;
      col_out    <= COL_OFF;
    end else begin
      state      <= nxt_state;
      row        <= nxt_row;
      shadow     <= nxt_shadow;
      active     <= nxt_active;
      pending    <= nxt_pending;
      frame_done <= nxt_done;
      if (nxt_state == ST_SHOW) begin
        row_out <= row_hot ^ ROW_OFF;
        col_out <= col_sel ^ COL_OFF;
      end else begin
        row_out <= ROW_OFF;
        col_out <= COL_OFF;
      end
    end
  end

  assign load_ready = ~pending;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_matrix_scan_driver : scoreboard bench for matrix_scan_driver    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_matrix_scan_driver;

  // Row r occupies bits r*5 +: 5; rows listed 6 down to 0.
  localparam logic [34:0] IMG_A = {5'b11011, 5'b01110, 5'b10001, 5'b11000,
                                   5'b00111, 5'b01010, 5'b10101};
  localparam logic [34:0] IMG_B = '1;
  localparam int FRAME_CYC = 42;
  localparam int ROW_CYC   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_valid;
  logic [34:0] frame_in;
  logic        load_ready, frame_done;
  logic [6:0]  row_out;
  logic [4:0]  col_out;
  logic        load_ready_n, frame_done_n;
  logic [6:0]  row_out_n;
  logic [4:0]  col_out_n;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    int         cyc;
    int         kind;
    logic [6:0] row;
    logic [4:0] col;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  matrix_scan_driver #(
    .COLS(5), .ROWS(7), .DWELL_CYC(4), .BLANK_CYC(2),
    .ROW_ACT_LOW(0), .COL_ACT_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_in(frame_in),
    .load_valid(load_valid), .load_ready(load_ready),
    .row_out(row_out), .col_out(col_out), .frame_done(frame_done)
  );

  matrix_scan_driver #(
    .COLS(5), .ROWS(7), .DWELL_CYC(4), .BLANK_CYC(2),
    .ROW_ACT_LOW(1), .COL_ACT_LOW(1)
  ) dut_n (
    .clk(clk), .rst(rst), .en(en), .frame_in(frame_in),
    .load_valid(load_valid), .load_ready(load_ready_n),
    .row_out(row_out_n), .col_out(col_out_n), .frame_done(frame_done_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kind_name(input int k);
    case (k)
      0: return "reset";
      1: return "load";
      2: return "scan";
      3: return "idle";
      4: return "rescan";
      5: return "actlow";
      default: return "other";
    endcase
  endfunction

  function automatic void push(input int which, input int kind, input int c,
                               input logic [6:0] r, input logic [4:0] col,
                               input logic d, input logic rd);
    exp_t e;
    e.cyc = c; e.kind = kind; e.row = r; e.col = col; e.done = d; e.ready = rd;
    if (which == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endfunction

  // Expected active-high outputs of a free-running scan begun at 'start'.
  function automatic void push_scan(input int kind, input int start, input int from,
                                    input int to, input int swap_at,
                                    input int busy_from, input int busy_to);
    int off, r;
    logic [34:0] img;
    logic [6:0]  ro;
    logic [4:0]  co;
    for (int c = from; c <= to; c++) begin
      off = (c - start) % FRAME_CYC;
      r   = off / ROW_CYC;
      img = (c >= swap_at) ? IMG_B : IMG_A;
      ro  = '0;
      co  = '0;
      if ((off % ROW_CYC) >= 2) begin
        ro[r] = 1'b1;
        co    = img[r*5 +: 5];
      end
      push(0, kind, c, ro, co, (off == 0) && (c > start),
           !((c >= busy_from) && (c <= busy_to)));
    end
  endfunction

  function automatic void check(input exp_t e, input logic [6:0] r, input logic [4:0] c,
                                input logic d, input logic rd);
    total++;
    if (e.cyc != cyc || r !== e.row || c !== e.col || d !== e.done || rd !== e.ready) begin
      bad++;
      $display("FAIL %s cyc=%0d (exp cyc %0d): got row=%b col=%b done=%b ready=%b, want row=%b col=%b done=%b ready=%b",
               kind_name(e.kind), cyc, e.cyc, r, c, d, rd, e.row, e.col, e.done, e.ready);
    end
  endfunction

  always @(negedge clk) begin
    while (sb0.size() > 0 && sb0[0].cyc <= cyc)
      check(sb0.pop_front(), row_out, col_out, frame_done, load_ready);
    while (sb1.size() > 0 && sb1[0].cyc <= cyc)
      check(sb1.pop_front(), row_out_n, col_out_n, frame_done_n, load_ready_n);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) tick();
  endtask

  initial begin
    #5000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    load_valid = 1'b1;
    frame_in   = '1;

    push(0, 0, 3, 7'b0, 5'b0, 1'b0, 1'b1);
    push(0, 0, 4, 7'b0, 5'b0, 1'b0, 1'b1);
    push(1, 5, 3,  7'b1111111, 5'b11111, 1'b0, 1'b1);
    push(1, 5, 7,  7'b1111111, 5'b11111, 1'b0, 1'b1);
    push(1, 5, 9,  7'b1111110, 5'b01010, 1'b0, 1'b1);
    push(1, 5, 15, 7'b1111101, 5'b10101, 1'b0, 1'b1);
    push(1, 5, 49, 7'b1111111, 5'b11111, 1'b1, 1'b1);

    wait_cyc(3);
    rst        = 1'b0;
    en         = 1'b0;
    load_valid = 1'b0;

    // Load while disabled swaps on the very next edge with no frame_done.
    wait_cyc(4);
    frame_in   = IMG_A;
    load_valid = 1'b1;
    push(0, 1, 5, 7'b0, 5'b0, 1'b0, 1'b0);
    push(0, 1, 6, 7'b0, 5'b0, 1'b0, 1'b1);
    wait_cyc(5);
    load_valid = 1'b0;

    wait_cyc(6);
    en = 1'b1;
    push_scan(2, 7, 7, 118, 91, 70, 90);

    // Frame B loaded while row 3 of frame 2 is lit; a second request is dropped.
    wait_cyc(69);
    frame_in   = IMG_B;
    load_valid = 1'b1;
    wait_cyc(70);
    frame_in   = '0;
    wait_cyc(73);
    load_valid = 1'b0;

    // Drop enable during SHOW of row 4, then resume from row 0.
    wait_cyc(118);
    en = 1'b0;
    for (int c = 119; c <= 121; c++) push(0, 3, c, 7'b0, 5'b0, 1'b0, 1'b1);
    push_scan(4, 122, 122, 135, 0, -1, -2);
    wait_cyc(121);
    en = 1'b1;

    wait_cyc(136);
    total++;
    if (sb0.size() + sb1.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb0.size() + sb1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
